// File: rtl/seven_segment_scan_alu.sv
// seven_segment_scan_alu
// Small 4-function ALU whose held result is shown as hex digits on a shared,
// time-multiplexed seven-segment bus with one-hot digit selects.
module seven_segment_scan_alu #(
  parameter int N        = 8,
  parameter int SCAN_DIV = 1000,
  parameter bit LZ_BLANK = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in0,
  input  logic [N-1:0]     in1,
  input  logic [1:0]       op_code,
  input  logic             enable,
  output logic [6:0]       seg,
  output logic [N/4-1:0]   dig_sel,
  output logic             ovf
);

  localparam int DIGITS = N / 4;
  // Keep counters at least one bit wide so SCAN_DIV=1 / DIGITS=1 still elaborate.
  localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [DIGITS-1:0] DIG_ONE  = DIGITS'(1);

  // Hex nibble to {a,b,c,d,e,f,g}, active high.
  function automatic logic [6:0] hex_decode(input logic [3:0] hex);
    logic [6:0] pattern;
    case (hex)
      4'h0:    pattern = 7'h7E;
      4'h1:    pattern = 7'h30;
      4'h2:    pattern = 7'h6D;
      4'h3:    pattern = 7'h79;
      4'h4:    pattern = 7'h33;
      4'h5:    pattern = 7'h5B;
      4'h6:    pattern = 7'h5F;
      4'h7:    pattern = 7'h70;
      4'h8:    pattern = 7'h7F;
      4'h9:    pattern = 7'h7B;
      4'hA:    pattern = 7'h77;
      4'hB:    pattern = 7'h1F;
      4'hC:    pattern = 7'h4E;
      4'hD:    pattern = 7'h3D;
      4'hE:    pattern = 7'h4F;
      4'hF:    pattern = 7'h47;
      default: pattern = 7'h00;
    endcase
    return pattern;
  endfunction

  logic [N-1:0]     result_r;
  logic [CNT_W-1:0] scan_cnt_r;
  logic [IDX_W-1:0] idx_r;

  logic [N:0]       sum_s;
  logic [N-1:0]     alu_res_s;
  logic             alu_ovf_s;
  logic [N-1:0]     shifted_s;
  logic [6:0]       seg_next_s;

  // ALU: result and carry/borrow for the operation currently selected.
  always_comb begin
    sum_s     = {1'b0, in0} + {1'b0, in1};
    alu_res_s = '0;
    alu_ovf_s = 1'b0;
    case (op_code)
      2'b00: begin
        alu_res_s = sum_s[N-1:0];
        alu_ovf_s = sum_s[N];
      end
      2'b01: begin
        alu_res_s = in0 | in1;
        alu_ovf_s = 1'b0;
      end
      2'b10: begin
        alu_res_s = in0 - in1;
        alu_ovf_s = (in0 < in1);
      end
      2'b11: begin
        alu_res_s = in0 ^ in1;
        alu_ovf_s = 1'b0;
      end
      default: begin
        alu_res_s = '0;
        alu_ovf_s = 1'b0;
      end
    endcase
  end

  // Capture the ALU result and flag only on enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= '0;
      ovf      <= 1'b0;
    end else if (enable) begin
      result_r <= alu_res_s;
      ovf      <= alu_ovf_s;
    end else begin
      result_r <= result_r;
      ovf      <= ovf;
    end
  end

  // Dwell counter and digit index for the display scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_r <= '0;
      idx_r      <= '0;
    end else if (scan_cnt_r == CNT_LAST) begin
      scan_cnt_r <= '0;
      if (idx_r == IDX_LAST) begin
        idx_r <= '0;
      end else begin
        idx_r <= idx_r + IDX_ONE;
      end
    end else begin
      scan_cnt_r <= scan_cnt_r + CNT_ONE;
      idx_r      <= idx_r;
    end
  end

  // Select the nibble for the current digit; the shifted value doubles as the
  // leading-zero test (everything at and above this digit is zero).
  always_comb begin
    shifted_s = result_r >> {idx_r, 2'b00};
    if (LZ_BLANK && (idx_r != '0) && (shifted_s == '0)) begin
      seg_next_s = 7'h00;
    end else begin
      seg_next_s = hex_decode(shifted_s[3:0]);
    end
  end

  // Register segment pattern and digit select together so they never skew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg     <= 7'h00;
      dig_sel <= '0;
    end else begin
      seg     <= seg_next_s;
      dig_sel <= DIG_ONE << idx_r;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_alu.sv
// Testbench for seven_segment_scan_alu: four instances (default 8-bit, blanking,
// SCAN_DIV=1, 16-bit) checked each cycle against an arithmetic reference model.
module tb_seven_segment_scan_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in0, in1;
  logic [15:0] in0w, in1w;
  logic [1:0]  op_code;
  logic        enable;

  logic [6:0]  seg_a, seg_b, seg_f, seg_w;
  logic [1:0]  dig_a, dig_b, dig_f;
  logic [3:0]  dig_w;
  logic        ovf_a, ovf_b, ovf_f, ovf_w;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_res8, m_ovf8, m_res16, m_ovf16, ecnt;
  logic [6:0] e_seg_a, e_seg_b, e_seg_f, e_seg_w;
  logic [1:0] e_dig_a, e_dig_f;
  logic [3:0] e_dig_w;
  logic       e_ovf8, e_ovf16;

  logic [6:0] hex_seg [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  seven_segment_scan_alu #(.N(8), .SCAN_DIV(4), .LZ_BLANK(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .op_code(op_code), .enable(enable),
    .seg(seg_a), .dig_sel(dig_a), .ovf(ovf_a));

  seven_segment_scan_alu #(.N(8), .SCAN_DIV(4), .LZ_BLANK(1'b1)) u_blank (
    .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .op_code(op_code), .enable(enable),
    .seg(seg_b), .dig_sel(dig_b), .ovf(ovf_b));

  seven_segment_scan_alu #(.N(8), .SCAN_DIV(1), .LZ_BLANK(1'b0)) u_fast (
    .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .op_code(op_code), .enable(enable),
    .seg(seg_f), .dig_sel(dig_f), .ovf(ovf_f));

  seven_segment_scan_alu #(.N(16), .SCAN_DIV(4), .LZ_BLANK(1'b0)) u_wide (
    .clk(clk), .rst_n(rst_n), .in0(in0w), .in1(in1w), .op_code(op_code), .enable(enable),
    .seg(seg_w), .dig_sel(dig_w), .ovf(ovf_w));

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(int v, int d, bit blank);
    int up;
    up = v >> (4 * d);
    if (blank && d > 0 && up == 0) return 7'h00;
    return hex_seg[up % 16];
  endfunction

  function automatic int ref_alu(int a, int b, int o, int w, output int ov);
    int modv, r;
    modv = 1 << w;
    case (o)
      0: begin r = a + b; ov = (r >= modv) ? 1 : 0; r = r % modv; end
      1: begin r = a | b; ov = 0; end
      2: begin r = (a - b + modv) % modv; ov = (a < b) ? 1 : 0; end
      default: begin r = a ^ b; ov = 0; end
    endcase
    return r;
  endfunction

  task automatic model_reset();
    ecnt = 0; m_res8 = 0; m_ovf8 = 0; m_res16 = 0; m_ovf16 = 0;
    e_seg_a = 7'h00; e_seg_b = 7'h00; e_seg_f = 7'h00; e_seg_w = 7'h00;
    e_dig_a = 2'b00; e_dig_f = 2'b00; e_dig_w = 4'b0000;
    e_ovf8 = 1'b0; e_ovf16 = 1'b0;
  endtask

  // Advance one clock: model the edge using inputs present at it, end on negedge.
  task automatic step();
    int a, b, aw, bw, o, ov, e, d8, df, dw;
    bit en;
    a = int'(in0); b = int'(in1); aw = int'(in0w); bw = int'(in1w);
    o = int'(op_code); en = enable;
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      model_reset();
    end else begin
      e  = ecnt;
      d8 = (e / 4) % 2;
      df = e % 2;
      dw = (e / 4) % 4;
      e_dig_a = 2'(1 << d8);
      e_dig_f = 2'(1 << df);
      e_dig_w = 4'(1 << dw);
      e_seg_a = ref_seg(m_res8, d8, 1'b0);
      e_seg_b = ref_seg(m_res8, d8, 1'b1);
      e_seg_f = ref_seg(m_res8, df, 1'b0);
      e_seg_w = ref_seg(m_res16, dw, 1'b0);
      if (en) begin
        m_res8  = ref_alu(a, b, o, 8, ov);   m_ovf8  = ov;
        m_res16 = ref_alu(aw, bw, o, 16, ov); m_ovf16 = ov;
      end
      ecnt++;
      e_ovf8  = (m_ovf8 != 0);
      e_ovf16 = (m_ovf16 != 0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [1:0] want;
    rst_n = 1'b0; in0 = 8'h00; in1 = 8'h00; in0w = 16'h0000; in1w = 16'h0000;
    op_code = 2'b00; enable = 1'b0;
    model_reset();
    step(); step();
    total++;
    if ({seg_a, dig_a, ovf_a} !== 10'h000)
      $display("FAIL reset_hold: got seg=%h dig=%b ovf=%b want 00/00/0", seg_a, dig_a, ovf_a);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      want = (((i / 4) % 2) == 1) ? 2'b10 : 2'b01;
      total++;
      if (dig_a !== want) begin
        bad++; $display("FAIL reset_scan cyc %0d: got dig=%b want %b", i, dig_a, want);
      end
      if (i == 0) begin
        total++;
        if (seg_a !== 7'h7E) begin
          bad++; $display("FAIL reset_first_seg: got %h want 7e", seg_a);
        end
      end
    end
    // capture something with a carry, then reset asynchronously mid-scan
    in0 = 8'hF0; in1 = 8'h25; enable = 1'b1; step(); enable = 1'b0;
    step(); step(); step();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({seg_a, dig_a, ovf_a, seg_w, dig_w, ovf_w} !== 24'h000000) begin
      bad++;
      $display("FAIL async_reset: got seg=%h dig=%b ovf=%b wseg=%h wdig=%b wovf=%b want zeros",
               seg_a, dig_a, ovf_a, seg_w, dig_w, ovf_w);
    end
    model_reset();
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step();
    total++;
    if ({seg_a, dig_a, ovf_a} !== {7'h7E, 2'b01, 1'b0}) begin
      bad++; $display("FAIL reset_release: got seg=%h dig=%b ovf=%b want 7e/01/0", seg_a, dig_a, ovf_a);
    end
  endtask

  task automatic test_add();
    in0 = 8'hF0; in1 = 8'h25; op_code = 2'b00; enable = 1'b1;
    in0w = 16'hFFF0; in1w = 16'h0025;
    step(); enable = 1'b0;
    total++;
    if ({ovf_a, ovf_w} !== 2'b11) begin
      bad++; $display("FAIL add_ovf: got %b%b want 11", ovf_a, ovf_w);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if ({seg_a, dig_a, ovf_a, seg_w, dig_w, ovf_w} !== {e_seg_a, e_dig_a, e_ovf8, e_seg_w, e_dig_w, e_ovf16}) begin
        bad++; $display("FAIL add_model cyc %0d: got %h/%b/%b %h/%b/%b want %h/%b/%b %h/%b/%b", i,
                        seg_a, dig_a, ovf_a, seg_w, dig_w, ovf_w, e_seg_a, e_dig_a, e_ovf8, e_seg_w, e_dig_w, e_ovf16);
      end
      total++;
      if (!((dig_a == 2'b01 && seg_a === 7'h5B) || (dig_a == 2'b10 && seg_a === 7'h30))) begin
        bad++; $display("FAIL add_digit: got dig=%b seg=%h want 01/5b or 10/30", dig_a, seg_a);
      end
    end
  endtask

  task automatic test_sub();
    in0 = 8'h03; in1 = 8'h05; op_code = 2'b10; enable = 1'b1;
    step(); enable = 1'b0;
    total++;
    if (ovf_a !== 1'b1) begin
      bad++; $display("FAIL sub_ovf: got %b want 1", ovf_a);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (!((dig_a == 2'b01 && seg_a === 7'h4F) || (dig_a == 2'b10 && seg_a === 7'h47))) begin
        bad++; $display("FAIL sub_digit: got dig=%b seg=%h want 01/4f or 10/47", dig_a, seg_a);
      end
    end
    in0 = 8'hA5; in1 = 8'h0F; op_code = 2'b11; enable = 1'b1;
    step(); enable = 1'b0;
    total++;
    if (ovf_a !== 1'b0) begin
      bad++; $display("FAIL xor_ovf: got %b want 0", ovf_a);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (seg_a !== 7'h77 || {seg_a, dig_a} !== {e_seg_a, e_dig_a}) begin
        bad++; $display("FAIL xor_digit: got dig=%b seg=%h want dig=%b seg=77", dig_a, seg_a, e_dig_a);
      end
    end
  endtask

  task automatic test_hold();
    enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      in0 = 8'($urandom); in1 = 8'($urandom); op_code = 2'($urandom);
      in0w = 16'($urandom); in1w = 16'($urandom);
      step();
      total++;
      if ({seg_a, dig_a, ovf_a} !== {7'h77, e_dig_a, 1'b0}) begin
        bad++; $display("FAIL hold cyc %0d: got %h/%b/%b want 77/%b/0", i, seg_a, dig_a, ovf_a, e_dig_a);
      end
    end
  endtask

  task automatic test_blank();
    in0 = 8'h07; in1 = 8'h00; op_code = 2'b01; enable = 1'b1;
    step(); enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if ({seg_b, dig_b} !== {((dig_b == 2'b01) ? 7'h70 : 7'h00), e_dig_a}) begin
        bad++; $display("FAIL blank_07: got dig=%b seg=%h want dig=%b seg=%h", dig_b, seg_b, e_dig_a, e_seg_b);
      end
    end
    in0 = 8'h00; enable = 1'b1;
    step(); enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if ({seg_b, dig_b} !== {((dig_b == 2'b01) ? 7'h7E : 7'h00), e_dig_a}) begin
        bad++; $display("FAIL blank_00: got dig=%b seg=%h want dig=%b seg=%h", dig_b, seg_b, e_dig_a, e_seg_b);
      end
    end
  endtask

  task automatic test_fast();
    logic [1:0] prev;
    prev = dig_f;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (dig_f === prev || {seg_f, dig_f} !== {e_seg_f, e_dig_f}) begin
        bad++; $display("FAIL fast_toggle cyc %0d: got dig=%b seg=%h prev=%b want dig=%b seg=%h",
                        i, dig_f, seg_f, prev, e_dig_f, e_seg_f);
      end
      prev = dig_f;
    end
  endtask

  task automatic test_wide();
    logic [3:0] prev;
    logic [6:0] want;
    in0w = 16'h1234; in1w = 16'h0000; op_code = 2'b01; enable = 1'b1;
    step(); enable = 1'b0;
    prev = dig_w;
    for (int i = 0; i < 16; i++) begin
      step();
      case (dig_w)
        4'b0001: want = 7'h33;
        4'b0010: want = 7'h79;
        4'b0100: want = 7'h6D;
        4'b1000: want = 7'h30;
        default: want = 7'hxx;
      endcase
      total++;
      if (seg_w !== want || dig_w !== e_dig_w) begin
        bad++; $display("FAIL wide_digit cyc %0d: got dig=%b seg=%h want dig=%b seg=%h", i, dig_w, seg_w, e_dig_w, want);
      end
      total++;
      if (dig_w !== prev && dig_w !== {prev[2:0], prev[3]}) begin
        bad++; $display("FAIL wide_rotate: got %b after %b want %b", dig_w, prev, {prev[2:0], prev[3]});
      end
      prev = dig_w;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      in0 = 8'($urandom); in1 = 8'($urandom); op_code = 2'($urandom);
      in0w = 16'($urandom); in1w = 16'($urandom);
      enable = ($urandom_range(0, 2) != 0);
      step();
      total++;
      if ({seg_a, dig_a, ovf_a, seg_b, dig_b, ovf_b} !== {e_seg_a, e_dig_a, e_ovf8, e_seg_b, e_dig_a, e_ovf8} ||
          {seg_f, dig_f, ovf_f, seg_w, dig_w, ovf_w} !== {e_seg_f, e_dig_f, e_ovf8, e_seg_w, e_dig_w, e_ovf16}) begin
        bad++;
        $display("FAIL random cyc %0d: got a=%h/%b/%b b=%h/%b/%b f=%h/%b/%b w=%h/%b/%b want a=%h/%b/%b b=%h f=%h/%b w=%h/%b/%b",
                 i, seg_a, dig_a, ovf_a, seg_b, dig_b, ovf_b, seg_f, dig_f, ovf_f, seg_w, dig_w, ovf_w,
                 e_seg_a, e_dig_a, e_ovf8, e_seg_b, e_seg_f, e_dig_f, e_seg_w, e_dig_w, e_ovf16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_hold();
    test_blank();
    test_fast();
    test_wide();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
